pin_bus_master: RTL and testbench
=================================

Name: pin_bus_master

Overview:
- Self-contained bus-master traffic generator for the pin-level request/acknowledge bus (address, wr_data, rd_data, rw, req, ack, err).
- On a start pulse it writes a deterministic data pattern to a block of addresses, reads the block back, compares, and reports pass/fail with error counters.
- It also exports a free-running cycle counter for debug and timestamping.
- It sits as the initiator on the bus, opposite a slave or memory model.

Parameters:
- ADDR_WIDTH, 16, address bus width.
- DW, 8, data bus width.
- NUM_XFERS, 16, number of addresses per pass (1..65535).
- BASE_ADDR, 0, first address of the block.
- SEED, 8'hA5, XOR pattern for write data.
- TIMEOUT, 255, maximum cycles to wait for ack/err.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle pulse that begins a test; ignored while busy.
- address  output  ADDR_WIDTH  transfer address.
- wr_data  output  DW  write data.
- rd_data  input  DW  read data, valid in any cycle where ack=1 for a read.
- rw  output  1  1 = write, 0 = read.
- req  output  1  transfer request.
- ack  input  1  slave completion.
- err  input  1  slave error completion.
- busy  output  1  test in progress.
- done  output  1  test finished; held until the next accepted start.
- pass  output  1  done with err_cnt=0 and mismatch_cnt=0.
- err_cnt  output  8  count of error or timed-out transfers; saturates at 255.
- mismatch_cnt  output  8  count of read-data mismatches; saturates at 255.
- cycle_count  output  16  free-running cycle counter.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, cycle_count=0.
- cycle_count: increments by 1 every clk while rst=1; wraps 16'hFFFF->0.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE/DONE:
  - Accepted start clears both counters, clears done and pass, sets busy.
  - It loads index=0 and enters WR_REQ.
  - req rises in the cycle after start is sampled, so latency is 1 cycle.
- Address generation: address = (BASE_ADDR + index) mod 2^ADDR_WIDTH.
- Expected/write data: (address[DW-1:0]) XOR SEED.
- WR_REQ:
  - Drive req=1, rw=1, address, wr_data; hold all stable until completion.
  - Completion is sampled at the posedge where ack=1 or err=1.
  - An error completion increments err_cnt.
  - Then go to WR_GAP with req=0.
- WR_GAP:
  - Keeps req low for exactly one cycle.
  - Then either increments index and returns to WR_REQ, or, after the last write, sets index=0 and enters RD_REQ.
- RD_REQ:
  - Drive req=1, rw=0, address; wr_data holds its last value.
  - When ack=1 and err=0, compare rd_data to the expected data; if they differ, increment mismatch_cnt.
  - err=1 increments err_cnt only, with no data compare.
  - Then go to RD_GAP.
- RD_GAP: one idle cycle; then the next read, or, after the last read, DONE.
- DONE: busy=0, done=1, pass=(err_cnt==0 && mismatch_cnt==0).
- Simultaneous ack and err: treated as error; err takes precedence.
- Timeout:
  - A per-transfer wait counter starts when req rises.
  - If TIMEOUT cycles elapse with neither ack nor err, abort the transfer, increment err_cnt, and proceed as for an err completion.
- No retries are performed.
- ack/err while req=0: ignored.
- Bus timing: each transfer takes at least 2 cycles (req + gap). A full pass with immediate acks takes 4*NUM_XFERS cycles from the first req to the DONE entry.
- Counters saturate at 8'hFF and never wrap.
- Reset asserted mid-test: immediate return to the reset state. A new start is required afterwards.
- start asserted while busy: ignored.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, then cycle_count=10 after 10 posedges; preload near 16'hFFFF -> wraps to 0.
- Start with a zero-wait memory slave, defaults -> writes 0x0000..0x000F with data 0xA5,0xA4,...,0xAA; reads match; done=1, pass=1, both counters 0; DONE entered 64 cycles after the first req.
- Slave inverts read data at address 0x0003 -> mismatch_cnt=1, err_cnt=0, pass=0.
- Slave asserts err on the write to 0x0005, and asserts ack+err together on the read of 0x0007 -> err_cnt=2, no mismatch counted for 0x0007, pass=0.
- Slave never responds at 0x0002, TIMEOUT=255 -> that transfer aborts after 255 cycles, err_cnt increments, the sequence continues to done=1.
- Slave with 3 wait states -> address/wr_data/rw stay stable for all req cycles; rst=0 pulse mid-read -> outputs 0 at once; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/pin_bus_master.sv
// Pin-level bus master traffic generator: writes an XOR pattern to a block of
// addresses, reads it back, and reports error/mismatch counts plus a cycle counter.
module pin_bus_master #(
   parameter int              ADDR_WIDTH = 16,
   parameter int              DW         = 8,
   parameter int              NUM_XFERS  = 16,
   parameter int              BASE_ADDR  = 0,
   parameter logic [DW-1:0]   SEED       = 8'hA5,
   parameter int              TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DW-1:0]         wr_data,
   input  logic [DW-1:0]         rd_data,
   output logic                  rw,
   output logic                  req,
   input  logic                  ack,
   input  logic                  err,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [7:0]            err_cnt,
   output logic [7:0]            mismatch_cnt,
   output logic [15:0]           cycle_count
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_GAP, S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [15:0]             r_index;
   logic [ADDR_WIDTH-1:0]   r_address;
   logic [DW-1:0]           r_wr_data;
   logic                    r_rw;
   logic [TW-1:0]           r_wait;
   logic [7:0]              r_err_cnt;
   logic [7:0]              r_mis_cnt;
   logic [15:0]             r_cycle;

   logic                    w_req;
   logic                    w_start;
   logic                    w_timeout;
   logic                    w_cpl;
   logic                    w_cpl_err;
   logic                    w_mismatch;
   logic                    w_last;
   logic [ADDR_WIDTH-1:0]   w_next_addr;
   logic [DW-1:0]           w_expect;

   assign w_req       = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
   assign w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // The request has been high for TIMEOUT cycles once the wait count reaches TIMEOUT-1.
   assign w_timeout   = w_req && !ack && !err && (r_wait == TW'(TIMEOUT - 1));
   assign w_cpl       = w_req && (ack || err || w_timeout);
   assign w_cpl_err   = w_req && (err || w_timeout);
   assign w_expect    = r_address[DW-1:0] ^ SEED;
   assign w_mismatch  = (r_state == S_RD_REQ) && ack && !err && (rd_data != w_expect);
   assign w_last      = (r_index == 16'(NUM_XFERS - 1));
   assign w_next_addr = r_address + ADDR_WIDTH'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_state_next = S_WR_REQ;
         S_WR_REQ:       if (w_cpl) w_state_next = S_WR_GAP;
         S_WR_GAP:       w_state_next = w_last ? S_RD_REQ : S_WR_REQ;
         S_RD_REQ:       if (w_cpl) w_state_next = S_RD_GAP;
         S_RD_GAP:       w_state_next = w_last ? S_DONE : S_RD_REQ;
         default:        w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_index   <= '0;
         r_address <= '0;
         r_wr_data <= '0;
         r_rw      <= 1'b0;
         r_wait    <= '0;
         r_err_cnt <= '0;
         r_mis_cnt <= '0;
         r_cycle   <= '0;
      end else begin
         r_cycle <= r_cycle + 16'd1;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_index   <= '0;
                  r_address <= BASE;
                  r_wr_data <= BASE[DW-1:0] ^ SEED;
                  r_rw      <= 1'b1;
                  r_wait    <= '0;
               end
            end
            S_WR_REQ, S_RD_REQ: begin
               r_wait <= w_cpl ? '0 : r_wait + TW'(1);
            end
            S_WR_GAP: begin
               if (w_last) begin
                  r_index   <= '0;
                  r_address <= BASE;
                  r_rw      <= 1'b0;
               end else begin
                  r_index   <= r_index + 16'd1;
                  r_address <= w_next_addr;
                  r_wr_data <= w_next_addr[DW-1:0] ^ SEED;
               end
            end
            S_RD_GAP: begin
               if (!w_last) begin
                  r_index   <= r_index + 16'd1;
                  r_address <= w_next_addr;
               end
            end
            default: ;
         endcase

         // Counters saturate at 8'hFF so a long failing run never reads as clean.
         if (w_start) begin
            r_err_cnt <= '0;
            r_mis_cnt <= '0;
         end else begin
            if (w_cpl_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_mismatch && (r_mis_cnt != 8'hFF)) r_mis_cnt <= r_mis_cnt + 8'd1;
         end
      end
   end

   assign address      = r_address;
   assign wr_data      = r_wr_data;
   assign rw           = r_rw;
   assign req          = w_req;
   assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done         = (r_state == S_DONE);
   assign pass         = done && (r_err_cnt == 8'd0) && (r_mis_cnt == 8'd0);
   assign err_cnt      = r_err_cnt;
   assign mismatch_cnt = r_mis_cnt;
   assign cycle_count  = r_cycle;

endmodule

// File: tb/tb_pin_bus_master.sv
// Scoreboard bench for pin_bus_master: a configurable slave model answers the bus,
// stimulus pushes expected transfers, and a monitor compares each completed transfer.
module tb_pin_bus_master;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] address;
   logic [7:0]  wr_data;
   logic [7:0]  rd_data;
   logic        rw;
   logic        req;
   logic        ack;
   logic        err;
   logic        busy;
   logic        done;
   logic        pass;
   logic [7:0]  err_cnt;
   logic [7:0]  mismatch_cnt;
   logic [15:0] cycle_count;

   pin_bus_master #(.TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .start(start),
      .address(address), .wr_data(wr_data), .rd_data(rd_data),
      .rw(rw), .req(req), .ack(ack), .err(err),
      .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .mismatch_cnt(mismatch_cnt), .cycle_count(cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed write/expected data for addresses 0..15 with SEED 0xA5.
   logic [7:0] pat [16] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2,
                            8'hAD, 8'hAC, 8'hAF, 8'hAE, 8'hA9, 8'hA8, 8'hAB, 8'hAA};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- slave model ----------------
   logic [7:0] mem [16];
   int         ws_cfg = 0;
   logic       noresp_en = 0, werr_en = 0, both_en = 0, corrupt_en = 0, spurious_en = 0;
   int         ws_cnt = 0;

   always_comb begin
      ack     = 1'b0;
      err     = 1'b0;
      rd_data = 8'h00;
      if (req && ws_cnt >= ws_cfg && !(noresp_en && address == 16'h0002)) begin
         ack = 1'b1;
         if (werr_en && rw && address == 16'h0005) begin
            ack = 1'b0;
            err = 1'b1;
         end
         if (both_en && !rw && address == 16'h0007) err = 1'b1;
      end
      if (!req && spurious_en) ack = 1'b1;
      rd_data = mem[address[3:0]];
      if (corrupt_en && address == 16'h0003) rd_data = rd_data ^ 8'hFF;
      if (err) rd_data = rd_data ^ 8'h5A;
   end

   always @(posedge clk) begin
      if (!req || ack || err) ws_cnt <= 0;
      else ws_cnt <= ws_cnt + 1;
      if (req && rw && ack && !err) mem[address[3:0]] <= wr_data;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          is_end;
      bit          rw;
      logic [15:0] addr;
      logic [7:0]  data;
      bit          abort;
      logic [7:0]  ecnt;
      logic [7:0]  mcnt;
      bit          pass;
      int          dur;
   } exp_t;

   exp_t exp_q[$];

   task automatic push_test(input bit noresp2, input logic [7:0] ecnt, input logic [7:0] mcnt,
                            input bit p, input int dur);
      exp_t e;
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 16; i++) begin
            e = '{is_end: 1'b0, rw: (ph == 0), addr: 16'(i), data: pat[i],
                  abort: (noresp2 && i == 2), ecnt: 8'h0, mcnt: 8'h0, pass: 1'b0, dur: 0};
            exp_q.push_back(e);
         end
      end
      e = '{is_end: 1'b1, rw: 1'b0, addr: 16'h0, data: 8'h0, abort: 1'b0,
            ecnt: ecnt, mcnt: mcnt, pass: p, dur: dur};
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   bit          in_xfer = 0;
   bit          prev_done = 0;
   bit          seen_first = 0;
   int          cyc = 0;
   int          first_cyc = 0;
   int          rcnt = 0;
   logic [15:0] c_addr;
   logic        c_rw;
   logic [7:0]  c_wd;

   task automatic compare_item(input bit aborted);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_xfer", {c_rw, c_addr}, 17'h0);
         return;
      end
      e = exp_q.pop_front();
      chk("item_kind", e.is_end, 1'b0);
      chk("addr", c_addr, e.addr);
      chk("rw", c_rw, e.rw);
      if (e.rw) chk("wr_data", c_wd, e.data);
      chk("abort", aborted, e.abort);
      if (aborted) chk("timeout_len", rcnt, 255);
      $display("xfer %s addr=%04h wdata=%02h req_cycles=%0d%s", c_rw ? "WR" : "RD",
               c_addr, c_wd, rcnt, aborted ? " timeout" : "");
   endtask

   task automatic compare_end();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_done", 1'b1, 1'b0);
         return;
      end
      e = exp_q.pop_front();
      chk("end_kind", e.is_end, 1'b1);
      chk("err_cnt", err_cnt, e.ecnt);
      chk("mismatch_cnt", mismatch_cnt, e.mcnt);
      chk("pass", pass, e.pass);
      chk("busy_at_done", busy, 1'b0);
      if (e.dur > 0) chk("done_latency", cyc - first_cyc, e.dur);
      $display("done err_cnt=%0d mismatch_cnt=%0d pass=%0b cycles=%0d",
               err_cnt, mismatch_cnt, pass, cyc - first_cyc);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         in_xfer   = 0;
         prev_done = 0;
      end else begin
         cyc++;
         if (req) begin
            if (!in_xfer) begin
               in_xfer = 1;
               c_addr  = address;
               c_rw    = rw;
               c_wd    = wr_data;
               rcnt    = 0;
               if (!seen_first) begin
                  seen_first = 1;
                  first_cyc  = cyc;
               end
            end else begin
               chk("bus_stable", {address, rw, wr_data}, {c_addr, c_rw, c_wd});
            end
            rcnt++;
            if (ack || err) begin
               compare_item(1'b0);
               in_xfer = 0;
            end
         end else if (in_xfer) begin
            compare_item(1'b1);
            in_xfer = 0;
         end
         if (done && !prev_done) compare_end();
         prev_done = done;
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_pass();
      seen_first = 0;
      pulse_start();
      for (int i = 0; i < 1500 && !done; i++) @(negedge clk);
      chk("done_seen", done, 1'b1);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bus"}, {req, rw, address, wr_data}, 26'h0);
      chk({tag, "_status"}, {busy, done, pass}, 3'b000);
      chk({tag, "_counters"}, {err_cnt, mismatch_cnt}, 16'h0);
      chk({tag, "_cycle_count"}, cycle_count, 16'h0);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("idle_req", {req, busy, done}, 3'b000);
      chk("cycle_count_10", cycle_count, 16'd10);
      repeat (65526) @(posedge clk);
      @(negedge clk);
      chk("cycle_count_wrap", cycle_count, 16'd0);

      // Zero-wait slave: clean pass, DONE 64 cycles after first req.
      push_test(1'b0, 8'd0, 8'd0, 1'b1, 64);
      run_pass();

      // Read data inverted at 0x0003, spurious acks while req is low.
      corrupt_en  = 1;
      spurious_en = 1;
      push_test(1'b0, 8'd0, 8'd1, 1'b0, 64);
      run_pass();
      corrupt_en  = 0;
      spurious_en = 0;

      // err on write 0x0005, ack+err on read 0x0007.
      werr_en = 1;
      both_en = 1;
      push_test(1'b0, 8'd2, 8'd0, 1'b0, 64);
      run_pass();
      werr_en = 0;
      both_en = 0;

      // No response at 0x0002: both transfers time out after 255 cycles.
      noresp_en = 1;
      push_test(1'b1, 8'd2, 8'd0, 1'b0, 64 + 2 * 254);
      run_pass();
      noresp_en = 0;

      // Three wait states, start while busy, then reset during a read.
      ws_cfg = 3;
      push_test(1'b0, 8'd0, 8'd0, 1'b1, 0);
      seen_first = 0;
      pulse_start();
      repeat (9) @(negedge clk);
      pulse_start();
      chk("busy_after_restart_attempt", busy, 1'b1);
      for (int i = 0; i < 1000 && !(req && !rw); i++) @(negedge clk);
      chk("reached_read", {req, rw}, 2'b10);
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("midreset");
      exp_q.delete();
      @(negedge clk);
      #2;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_resume", {req, busy, done}, 3'b000);

      // Fresh start after reset recovers fully.
      ws_cfg = 0;
      push_test(1'b0, 8'd0, 8'd0, 1'b1, 64);
      run_pass();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
